// File: rtl/baud_tick_ctrl_pkg.sv
// Shared definitions for the baud tick controller: FSM state encoding and
// divisor constants for the 12 MHz board clock.
package baud_tick_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned BOARD_CLK_HZ = 12_000_000;

  // Integer divisors; the fractional remainder is the accepted baud error.
  localparam int unsigned B9600   = BOARD_CLK_HZ / 9600;
  localparam int unsigned B19200  = BOARD_CLK_HZ / 19200;
  localparam int unsigned B115200 = BOARD_CLK_HZ / 115200;

  localparam int unsigned DEF_DIV_W = 16;
  localparam int unsigned DEF_CNT_W = 4;
  localparam int unsigned MIN_DIV   = 2;

  function automatic logic state_busy(input state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/baud_tick_ctrl_counter.sv
// Modulo-div counter: counts while en, wraps to 0 on terminal count, clr wins.
// tc is combinational from the registered count; no backpressure.
module baud_tick_ctrl_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] cnt,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] cnt_q;

  assign cnt = cnt_q;
  assign tc  = en && !clr && (cnt_q == div - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/baud_tick_ctrl.sv
// Burst tick sequencer: N one-cycle ticks spaced div_q cycles after start, then done; registered outputs,
// config only accepted in IDLE (cfg_ready). Optional mid-period half_tick when BAUD_HALF_TICK_EN is defined.
module baud_tick_ctrl
  import baud_tick_ctrl_pkg::*;
#(
  parameter int          DIV_W   = 16,
  parameter int          CNT_W   = 4,
  parameter int unsigned DEF_DIV = B115200
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             start,
  input  logic [CNT_W-1:0] nticks,
  input  logic             abort,
  output logic             busy,
  output logic             tick,
  output logic             done
`ifdef BAUD_HALF_TICK_EN
  ,
  output logic             half_tick
`endif
);

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] rem_q;
  logic             tick_q;
  logic             done_q;

  logic             run;
  logic [DIV_W-1:0] cnt;
  logic             tc;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
  endfunction

  assign run       = (state_q == ST_RUN);
  assign busy      = state_busy(state_q);
  assign cfg_ready = (state_q == ST_IDLE);
  assign tick      = tick_q;
  assign done      = done_q;

  // Counter only advances in RUN; abort clears it on the same edge as the FSM.
  baud_tick_ctrl_counter #(
    .DIV_W(DIV_W)
  ) u_counter (
    .clk_in(clk_in),
    .rstn  (rstn),
    .clr   (abort || !run),
    .en    (run),
    .div   (div_q),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_W'(DEF_DIV);
      rem_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (cfg_valid && cfg_ready) begin
        div_q <= clamp_div(cfg_div);
      end
      if (abort) begin
        state_q <= ST_IDLE;
        rem_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && (nticks != '0)) begin
              state_q <= ST_RUN;
              rem_q   <= nticks;
            end
          end
          ST_RUN: begin
            if (tc) begin
              tick_q <= 1'b1;
              rem_q  <= rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_q <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef BAUD_HALF_TICK_EN
  logic half_q;
  logic half_hit;

  // div_q >= 2, so the midpoint compare never underflows.
  assign half_hit  = run && !abort && (cnt == (div_q >> 1) - DIV_W'(1));
  assign half_tick = half_q;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      half_q <= 1'b0;
    end else begin
      half_q <= half_hit;
    end
  end
`endif

  cnt_in_range : assert property (@(posedge clk_in) disable iff (!rstn) cnt < div_q);

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Directed bench for baud_tick_ctrl: table of config/burst vectors plus hand-written
// sequences for zero-length start, busy hold-off, abort, and reset mid-burst.
module tb_baud_tick_ctrl;

  localparam int DIV_W = 16;
  localparam int CNT_W = 4;
`ifdef BAUD_HALF_TICK_EN
  localparam bit HALF_ON = 1'b1;
`else
  localparam bit HALF_ON = 1'b0;
`endif

  logic             clk_in    = 1'b0;
  logic             rstn      = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div   = '0;
  logic             start     = 1'b0;
  logic [CNT_W-1:0] nticks    = '0;
  logic             abort     = 1'b0;
  logic             cfg_ready;
  logic             busy;
  logic             tick;
  logic             done;
  logic             half_obs;

`ifdef BAUD_HALF_TICK_EN
  logic half_tick;
  assign half_obs = half_tick;
`else
  assign half_obs = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_in = ~clk_in;

  baud_tick_ctrl dut (
    .clk_in   (clk_in),
    .rstn     (rstn),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .start    (start),
    .nticks   (nticks),
    .abort    (abort),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
`ifdef BAUD_HALF_TICK_EN
    ,
    .half_tick(half_tick)
`endif
  );

  typedef struct {
    bit    do_cfg;
    int    cfg;
    int    n;
    int    eff;
    string name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Packed as {tick, done, busy, half_tick}
  function automatic logic [3:0] obs();
    return {tick, done, busy, half_obs};
  endfunction

  // j = cycles since the start-sampling edge E0, sampled on the falling edge after E0+j.
  function automatic logic [3:0] expv(input int j, input int div, input int n);
    logic t, d, b, h;
    t = (j >= 1) && (j % div == 0) && (j <= n * div);
    d = (j == n * div + 1);
    b = (j <= n * div);
    h = HALF_ON && (j >= 1) && (j % div == div / 2) && (j <= n * div);
    return {t, d, b, h};
  endfunction

  task automatic do_cfg(input int d);
    cfg_valid = 1'b1;
    cfg_div   = DIV_W'(d);
    check($sformatf("cfg_ready_idle d=%0d", d), 32'(cfg_ready), 32'd1);
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  task automatic run_burst(input int div, input int n, input string name);
    start  = 1'b1;
    nticks = CNT_W'(n);
    @(negedge clk_in);
    start = 1'b0;
    for (int j = 0; j <= n * div + 2; j++) begin
      check($sformatf("%s j=%0d", name, j), 32'(obs()), 32'(expv(j, div, n)));
      @(negedge clk_in);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 0, 3, 104, "default104_n3"};
    vecs[1] = '{1'b1, 4, 10, 4, "div4_n10"};
    vecs[2] = '{1'b1, 0, 2, 2, "div0_as2_n2"};
    vecs[3] = '{1'b1, 1, 2, 2, "div1_as2_n2"};
    vecs[4] = '{1'b1, 3, 15, 3, "div3_n15"};
    vecs[5] = '{1'b1, 10, 2, 10, "div10_n2"};
    vecs[6] = '{1'b1, 7, 1, 7, "div7_n1"};

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_outputs", 32'(obs()), 32'd0);
    rstn = 1'b1;
    @(negedge clk_in);
    check("post_rst_outputs", 32'(obs()), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].do_cfg) do_cfg(vecs[i].cfg);
      run_burst(vecs[i].eff, vecs[i].n, vecs[i].name);
    end

    // start with nticks==0 (held as a level) is ignored
    do_cfg(4);
    start  = 1'b1;
    nticks = '0;
    for (int j = 0; j < 12; j++) begin
      if (j == 3) start = 1'b0;
      @(negedge clk_in);
      check($sformatf("nticks0 j=%0d", j), 32'(obs()), 32'd0);
    end
    check("nticks0_cfg_ready", 32'(cfg_ready), 32'd1);

    // start and cfg_valid while busy are ignored
    do_cfg(5);
    start  = 1'b1;
    nticks = CNT_W'(3);
    @(negedge clk_in);
    start = 1'b0;
    for (int j = 0; j <= 22; j++) begin
      check($sformatf("busy_ign j=%0d", j), 32'(obs()), 32'(expv(j, 5, 3)));
      if (j == 3) begin
        start     = 1'b1;
        nticks    = CNT_W'(15);
        cfg_valid = 1'b1;
        cfg_div   = DIV_W'(9);
        check("busy_cfg_ready", 32'(cfg_ready), 32'd0);
      end
      if (j == 4) begin
        start     = 1'b0;
        cfg_valid = 1'b0;
      end
      @(negedge clk_in);
    end
    run_burst(5, 1, "div_unchanged5");

    // abort on the terminal-count edge of tick 2 of 5
    do_cfg(4);
    start  = 1'b1;
    nticks = CNT_W'(5);
    @(negedge clk_in);
    start = 1'b0;
    for (int j = 0; j <= 20; j++) begin
      logic [3:0] e;
      e = {(j == 4), 1'b0, (j <= 7), HALF_ON && (j == 2 || j == 6)};
      check($sformatf("abort j=%0d", j), 32'(obs()), 32'(e));
      if (j == 7) abort = 1'b1;
      if (j == 8) abort = 1'b0;
      @(negedge clk_in);
    end
    run_burst(4, 2, "after_abort");

    // async reset while a tick is high restores outputs and default divisor
    do_cfg(6);
    start  = 1'b1;
    nticks = CNT_W'(4);
    @(negedge clk_in);
    start = 1'b0;
    repeat (6) @(negedge clk_in);
    check("pre_rst_tick", 32'(obs()), 32'(expv(6, 6, 4)));
    rstn = 1'b0;
    #1;
    check("midrst_outputs", 32'(obs()), 32'd0);
    check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk_in);
    rstn = 1'b1;
    @(negedge clk_in);
    check("post_midrst_outputs", 32'(obs()), 32'd0);
    run_burst(104, 1, "def_div_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
